// File: rtl/regs_pkg.sv
// Register numbering and write-back record layout shared by the register file and its write-back queue.
// Ids match the register file: 0..14 are real registers, 15 is the discard slot.
package regs_pkg;

    localparam int RW_DEF = 5;
    localparam int DW_DEF = 16;

    localparam logic [RW_DEF-1:0] RAX = 5'd0;
    localparam logic [RW_DEF-1:0] RCX = 5'd1;
    localparam logic [RW_DEF-1:0] RDX = 5'd2;
    localparam logic [RW_DEF-1:0] RBX = 5'd3;
    localparam logic [RW_DEF-1:0] RSP = 5'd4;
    localparam logic [RW_DEF-1:0] RBP = 5'd5;
    localparam logic [RW_DEF-1:0] RSI = 5'd6;
    localparam logic [RW_DEF-1:0] RDI = 5'd7;
    localparam logic [RW_DEF-1:0] R8  = 5'd8;
    localparam logic [RW_DEF-1:0] R9  = 5'd9;
    localparam logic [RW_DEF-1:0] R10 = 5'd10;
    localparam logic [RW_DEF-1:0] R11 = 5'd11;
    localparam logic [RW_DEF-1:0] R12 = 5'd12;
    localparam logic [RW_DEF-1:0] R13 = 5'd13;
    localparam logic [RW_DEF-1:0] R14 = 5'd14;
    localparam logic [RW_DEF-1:0] RNO = 5'd15;

    localparam int NOREG_DEF = 15;

    typedef struct packed {
        logic [RW_DEF-1:0] dstE;
        logic [DW_DEF-1:0] valE;
        logic [RW_DEF-1:0] dstM;
        logic [DW_DEF-1:0] valM;
    } wb_rec_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Combinational youngest-entry forwarding search for one lookup port; no state, no backpressure.
// Entries are walked oldest to youngest from the head so the last match (youngest) wins.
module wb_fwd_match #(
    parameter int DEPTH = 4,
    parameter int DW    = 16,
    parameter int RW    = 5,
    parameter int NOREG = 15
) (
    input  logic [RW-1:0]              i_src,
    input  logic [$clog2(DEPTH)-1:0]   i_head,
    input  logic [DEPTH-1:0]           i_vld,
    input  logic [DEPTH*RW-1:0]        i_dstE,
    input  logic [DEPTH*DW-1:0]        i_valE,
    input  logic [DEPTH*RW-1:0]        i_dstM,
    input  logic [DEPTH*DW-1:0]        i_valM,
    output logic                       o_hit,
    output logic [DW-1:0]              o_fwd
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [RW-1:0] NOREG_ID = RW'(NOREG);

    logic [AW-1:0] w_idx;

    always_comb begin
        o_hit = 1'b0;
        o_fwd = '0;
        w_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = i_head + AW'(k);
            // M is checked after E so it overrides, matching the register file write order
            if (i_vld[w_idx] && (i_src != NOREG_ID)) begin
                if (i_dstE[w_idx*RW +: RW] == i_src) begin
                    o_hit = 1'b1;
                    o_fwd = i_valE[w_idx*DW +: DW];
                end
                if (i_dstM[w_idx*RW +: RW] == i_src) begin
                    o_hit = 1'b1;
                    o_fwd = i_valM[w_idx*DW +: DW];
                end
            end
        end
    end

endmodule

// File: rtl/regs_wb_queue.sv
// Write-back FIFO in front of the register file with forwarding lookup; record accepted at edge N writes at edge N+1 if wb_en.
// Backpressure: in_ready = !full (no pass-through); wb_en=0 holds the head and rf_* show the discard slot.
module regs_wb_queue
    import regs_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = DW_DEF,
    parameter int RW    = RW_DEF,
    parameter int NOREG = NOREG_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [RW-1:0]              in_dstE,
    input  logic [DW-1:0]              in_valE,
    input  logic [RW-1:0]              in_dstM,
    input  logic [DW-1:0]              in_valM,
    input  logic                       wb_en,
    output logic [RW-1:0]              rf_dstE,
    output logic [DW-1:0]              rf_valE,
    output logic [RW-1:0]              rf_dstM,
    output logic [DW-1:0]              rf_valM,
    input  logic [RW-1:0]              srcA,
    input  logic [RW-1:0]              srcB,
    output logic                       hitA,
    output logic [DW-1:0]              fwdA,
    output logic                       hitB,
    output logic [DW-1:0]              fwdB,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [RW-1:0] NOREG_ID = RW'(NOREG);

    logic [DEPTH*RW-1:0] r_dstE;
    logic [DEPTH*DW-1:0] r_valE;
    logic [DEPTH*RW-1:0] r_dstM;
    logic [DEPTH*DW-1:0] r_valM;
    logic [DEPTH-1:0]    r_vld;
    logic [AW-1:0]       r_head;
    logic [AW-1:0]       r_tail;
    logic [CW-1:0]       r_count;

    logic          w_push;
    logic          w_pop;
    logic [RW-1:0] w_in_dstE;
    logic [RW-1:0] w_in_dstM;

    assign empty    = (r_count == '0);
    assign full     = (r_count == CW'(DEPTH));
    assign count    = r_count;
    assign in_ready = !full;

    // Reset also suppresses the drain so the register file sees no write on a reset edge
    assign w_push = in_valid && in_ready && rst_n;
    assign w_pop  = wb_en && !empty && rst_n;

    // Out-of-range ids collapse to the discard slot so the register file index stays below 16
    assign w_in_dstE = (in_dstE >= NOREG_ID) ? NOREG_ID : in_dstE;
    assign w_in_dstM = (in_dstM >= NOREG_ID) ? NOREG_ID : in_dstM;

    always_comb begin
        rf_dstE = NOREG_ID;
        rf_valE = '0;
        rf_dstM = NOREG_ID;
        rf_valM = '0;
        if (w_pop) begin
            rf_dstE = r_dstE[r_head*RW +: RW];
            rf_valE = r_valE[r_head*DW +: DW];
            rf_dstM = r_dstM[r_head*RW +: RW];
            rf_valM = r_valM[r_head*DW +: DW];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_vld   <= '0;
        end else begin
            if (w_push) begin
                r_dstE[r_tail*RW +: RW] <= w_in_dstE;
                r_valE[r_tail*DW +: DW] <= in_valE;
                r_dstM[r_tail*RW +: RW] <= w_in_dstM;
                r_valM[r_tail*DW +: DW] <= in_valM;
                r_vld[r_tail]           <= 1'b1;
                r_tail                  <= r_tail + AW'(1);
            end
            if (w_pop) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= r_head + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    wb_fwd_match #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .RW    (RW),
        .NOREG (NOREG)
    ) u_fwd_a (
        .i_src  (srcA),
        .i_head (r_head),
        .i_vld  (r_vld),
        .i_dstE (r_dstE),
        .i_valE (r_valE),
        .i_dstM (r_dstM),
        .i_valM (r_valM),
        .o_hit  (hitA),
        .o_fwd  (fwdA)
    );

    wb_fwd_match #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .RW    (RW),
        .NOREG (NOREG)
    ) u_fwd_b (
        .i_src  (srcB),
        .i_head (r_head),
        .i_vld  (r_vld),
        .i_dstE (r_dstE),
        .i_valE (r_valE),
        .i_dstM (r_dstM),
        .i_valM (r_valM),
        .o_hit  (hitB),
        .o_fwd  (fwdB)
    );

endmodule

// File: tb/tb_regs_wb_queue.sv
// Scoreboard bench for regs_wb_queue: queue model of pending records plus a register file fed from rf_*.
module tb_regs_wb_queue;
    import regs_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_dstE;
    logic [15:0] in_valE;
    logic [4:0]  in_dstM;
    logic [15:0] in_valM;
    logic        wb_en;
    logic [4:0]  rf_dstE;
    logic [15:0] rf_valE;
    logic [4:0]  rf_dstM;
    logic [15:0] rf_valM;
    logic [4:0]  srcA;
    logic [4:0]  srcB;
    logic        hitA;
    logic [15:0] fwdA;
    logic        hitB;
    logic [15:0] fwdB;
    logic [2:0]  count;
    logic        empty;
    logic        full;

    wb_rec_t     sb[$];
    logic [15:0] regs_m[16];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    regs_wb_queue #(.DEPTH(DEPTH), .DW(16), .RW(5), .NOREG(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_dstE(in_dstE), .in_valE(in_valE), .in_dstM(in_dstM), .in_valM(in_valM),
        .wb_en(wb_en),
        .rf_dstE(rf_dstE), .rf_valE(rf_valE), .rf_dstM(rf_dstM), .rf_valM(rf_valM),
        .srcA(srcA), .srcB(srcB),
        .hitA(hitA), .fwdA(fwdA), .hitB(hitB), .fwdB(fwdB),
        .count(count), .empty(empty), .full(full)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] san(input logic [4:0] id);
        return (id >= 5'd15) ? 5'd15 : id;
    endfunction

    task automatic model_fwd(input logic [4:0] src, output logic hit, output logic [15:0] val);
        hit = 1'b0;
        val = 16'h0;
        if (src != 5'd15) begin
            foreach (sb[i]) begin
                if (sb[i].dstE == src) begin hit = 1'b1; val = sb[i].valE; end
                if (sb[i].dstM == src) begin hit = 1'b1; val = sb[i].valM; end
            end
        end
    endtask

    // One clock: check outputs mid-cycle, retire into the register file model, then advance the model.
    task automatic step();
        logic        eh;
        logic [15:0] ef;
        logic        pop;
        logic        push;
        wb_rec_t     rec;
        @(negedge clk);
        check("count", 32'(count), 32'(sb.size()));
        check("empty", 32'(empty), 32'(sb.size() == 0));
        check("full", 32'(full), 32'(sb.size() == DEPTH));
        check("in_ready", 32'(in_ready), 32'(sb.size() < DEPTH));
        pop  = rst_n && wb_en && (sb.size() > 0);
        push = rst_n && in_valid && (sb.size() < DEPTH);
        if (pop) begin
            check("rf_dstE", 32'(rf_dstE), 32'(sb[0].dstE));
            check("rf_valE", 32'(rf_valE), 32'(sb[0].valE));
            check("rf_dstM", 32'(rf_dstM), 32'(sb[0].dstM));
            check("rf_valM", 32'(rf_valM), 32'(sb[0].valM));
        end else begin
            check("rf_dstE_idle", 32'(rf_dstE), 32'd15);
            check("rf_valE_idle", 32'(rf_valE), 32'd0);
            check("rf_dstM_idle", 32'(rf_dstM), 32'd15);
            check("rf_valM_idle", 32'(rf_valM), 32'd0);
        end
        model_fwd(srcA, eh, ef);
        check("hitA", 32'(hitA), 32'(eh));
        check("fwdA", 32'(fwdA), 32'(ef));
        model_fwd(srcB, eh, ef);
        check("hitB", 32'(hitB), 32'(eh));
        check("fwdB", 32'(fwdB), 32'(ef));
        if (rf_dstE != 5'd15) regs_m[rf_dstE[3:0]] = rf_valE;
        if (rf_dstM != 5'd15) regs_m[rf_dstM[3:0]] = rf_valM;
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (pop) void'(sb.pop_front());
            if (push) begin
                rec.dstE = san(in_dstE);
                rec.valE = in_valE;
                rec.dstM = san(in_dstM);
                rec.valM = in_valM;
                sb.push_back(rec);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] de, input logic [15:0] ve, input logic [4:0] dm, input logic [15:0] vm);
        in_valid = 1'b1;
        in_dstE  = de;
        in_valE  = ve;
        in_dstM  = dm;
        in_valM  = vm;
        step();
        in_valid = 1'b0;
        #1;
    endtask

    initial begin
        foreach (regs_m[i]) regs_m[i] = 16'h0;
        rst_n = 1'b0; in_valid = 1'b0; wb_en = 1'b0;
        in_dstE = 5'd15; in_valE = 16'h0; in_dstM = 5'd15; in_valM = 16'h0;
        srcA = 5'd0; srcB = 5'd0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_rf_dstE", 32'(rf_dstE), 32'd15);
        check("rst_fwdA", 32'(fwdA), 32'd0);

        // Reset while records are queued and a drain is requested
        push(5'd1, 16'h0011, 5'd15, 16'h0);
        push(5'd2, 16'h0022, 5'd15, 16'h0);
        push(5'd3, 16'h0033, 5'd15, 16'h0);
        wb_en = 1'b1; srcA = 5'd1; rst_n = 1'b0;
        #1;
        check("rstmid_rf_dstE", 32'(rf_dstE), 32'd15);
        check("rstmid_rf_dstM", 32'(rf_dstM), 32'd15);
        step();
        rst_n = 1'b1;
        #1;
        check("rstmid_count", 32'(count), 32'd0);
        check("rstmid_empty", 32'(empty), 32'd1);
        check("rstmid_hitA", 32'(hitA), 32'd0);
        step();
        check("rstmid_reg1", 32'(regs_m[1]), 32'd0);
        check("rstmid_reg3", 32'(regs_m[3]), 32'd0);

        // Basic write
        push(5'd2, 16'h1234, 5'd15, 16'h0);
        check("basic_rf_dstE", 32'(rf_dstE), 32'd2);
        check("basic_rf_valE", 32'(rf_valE), 32'h1234);
        step();
        check("basic_reg2", 32'(regs_m[2]), 32'h1234);
        check("basic_empty", 32'(empty), 32'd1);

        // Fill, overflow attempt, youngest forwarding
        wb_en = 1'b0;
        for (int v = 1; v <= 5; v++) push(5'd3, 16'(v), 5'd15, 16'h0);
        srcA = 5'd3;
        #1;
        check("full_full", 32'(full), 32'd1);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_count", 32'(count), 32'd4);
        check("full_hitA", 32'(hitA), 32'd1);
        check("full_fwdA", 32'(fwdA), 32'd4);
        wb_en = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("full_reg3", 32'(regs_m[3]), 32'd4);

        // M result overrides E result for the same id
        wb_en = 1'b0; srcB = 5'd7;
        push(5'd7, 16'hAAAA, 5'd7, 16'hBBBB);
        check("m_over_e_hitB", 32'(hitB), 32'd1);
        check("m_over_e_fwdB", 32'(fwdB), 32'hBBBB);
        wb_en = 1'b1;
        step();
        check("m_over_e_reg7", 32'(regs_m[7]), 32'hBBBB);

        // Steady push+pop at occupancy 2 across pointer wraps
        wb_en = 1'b0;
        push(5'd8, 16'h0800, 5'd15, 16'h0);
        push(5'd9, 16'h0900, 5'd15, 16'h0);
        wb_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push(5'(4 + i), 16'(16'h0100 + i), 5'd15, 16'h0);
            check("pp_count", 32'(count), 32'd2);
        end
        step(); step(); step();
        check("pp_reg8", 32'(regs_m[8]), 32'h0104);
        check("pp_reg13", 32'(regs_m[13]), 32'h0109);

        // Out-of-range ids are stored as the discard slot
        wb_en = 1'b0; srcA = 5'd20; srcB = 5'd15;
        push(5'd20, 16'h5555, 5'd31, 16'h6666);
        check("san_hitA", 32'(hitA), 32'd0);
        check("san_hitB", 32'(hitB), 32'd0);
        wb_en = 1'b1;
        #1;
        check("san_rf_dstE", 32'(rf_dstE), 32'd15);
        check("san_rf_dstM", 32'(rf_dstM), 32'd15);
        check("san_rf_valE", 32'(rf_valE), 32'h5555);
        step();

        // Random traffic with alternating fill and drain phases
        for (int i = 0; i < 300; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_dstE  = 5'($urandom_range(0, 31));
            in_valE  = 16'($urandom);
            in_dstM  = 5'($urandom_range(0, 31));
            in_valM  = 16'($urandom);
            wb_en    = ((i % 40) < 15) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            srcA     = 5'($urandom_range(0, 20));
            srcB     = 5'($urandom_range(0, 20));
            rst_n    = (i != 150);
            step();
        end
        rst_n = 1'b1; in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
